// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch bus arbiter.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_arb_state_e;

    localparam int FETCH_ADDR_W   = 32;
    localparam int FETCH_DATA_W   = 64;
    localparam int FETCH_MAX_WAYS = 4;

    typedef logic [1:0] way_idx_t;

    function automatic way_idx_t next_way(way_idx_t w, int num_ways);
        if ((int'(w) + 1) >= num_ways) begin
            return 2'd0;
        end else begin
            return w + 2'd1;
        end
    endfunction

endpackage

// File: rtl/fetch_bus_arbiter_chk.sv
// Protocol checks on the arbiter's one-hot outputs.
module fetch_bus_arbiter_chk #(
    parameter int NumWays = 2
) (
    input logic               clk,
    input logic               reset,
    input logic [NumWays-1:0] ready,
    input logic [NumWays-1:0] data_ok
);

    a_ready_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(ready));
    a_data_ok_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(data_ok));

endmodule

// File: rtl/fetch_bus_arbiter_rr_picker.sv
// Round-robin priority select: first requester at or above rr_ptr, wrapping.
module rr_picker
    import fetch_pkg::*;
#(
    parameter int NumWays = 2
) (
    input  logic [NumWays-1:0] req,
    input  way_idx_t           rr_ptr,
    output logic [NumWays-1:0] grant,
    output way_idx_t           idx,
    output logic               valid
);

    int best_dist_s;
    int dist_s;

    // Pick the requester with the smallest wrapped distance from rr_ptr.
    always_comb begin
        best_dist_s = NumWays;
        dist_s      = 0;
        idx         = 2'd0;
        for (int w = 0; w < NumWays; w++) begin
            dist_s = (w + NumWays - int'(rr_ptr)) % NumWays;
            if (req[w] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                idx         = way_idx_t'(w);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        valid = (best_dist_s < NumWays);
    end

    // Expand the chosen index to a one-hot grant.
    always_comb begin
        grant = '0;
        for (int w = 0; w < NumWays; w++) begin
            grant[w] = valid && (idx == way_idx_t'(w));
        end
    end

endmodule

// File: rtl/fetch_bus_arbiter.sv
// Round-robin arbiter sharing one instruction bus between fetch ways;
// single outstanding transaction, jump-kill of in-flight fetches, bus timeout.
module fetch_bus_arbiter
    import fetch_pkg::*;
#(
    parameter int NumWays       = 2,
    parameter int AddrWidth     = FETCH_ADDR_W,
    parameter int DataWidth     = FETCH_DATA_W,
    parameter int TimeoutCycles = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NumWays-1:0]             req_i,
    input  logic [NumWays*AddrWidth-1:0]   addr_i,
    input  logic                           jump_flag_i,
    output logic [NumWays-1:0]             ready_o,
    output logic [NumWays-1:0]             data_ok_o,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           busy_o,
    output logic                           err_o,
    output logic                           bus_req_o,
    output logic [AddrWidth-1:0]           bus_addr_o,
    input  logic                           bus_ack_i,
    input  logic                           bus_rvalid_i,
    input  logic [DataWidth-1:0]           bus_rdata_i
);

    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] TmoMax = CntW'(TimeoutCycles);

    fetch_arb_state_e       state_r, state_nxt_s;
    way_idx_t               rr_ptr_r;
    way_idx_t               owner_r;
    logic [AddrWidth-1:0]   addr_r;
    logic                   kill_r;
    logic [CntW-1:0]        tmo_cnt_r;

    logic [NumWays-1:0]     pick_grant_s;
    way_idx_t               pick_idx_s;
    logic                   pick_valid_s;
    logic [AddrWidth-1:0]   sel_addr_s;
    logic                   grant_fire_s;
    logic                   done_s;
    logic                   deliver_s;
    logic [NumWays-1:0]     owner_oh_s;

    rr_picker #(.NumWays(NumWays)) u_picker (
        .req    (req_i),
        .rr_ptr (rr_ptr_r),
        .grant  (pick_grant_s),
        .idx    (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // Address mux for the winning way and one-hot decode of the owner.
    always_comb begin
        sel_addr_s = '0;
        owner_oh_s = '0;
        for (int w = 0; w < NumWays; w++) begin
            if (pick_idx_s == way_idx_t'(w)) begin
                sel_addr_s = addr_i[w*AddrWidth +: AddrWidth];
            end else begin
                sel_addr_s = sel_addr_s;
            end
            owner_oh_s[w] = (owner_r == way_idx_t'(w));
        end
    end

    // Next-state logic and combinational grant.
    always_comb begin
        state_nxt_s  = state_r;
        grant_fire_s = 1'b0;
        done_s       = 1'b0;
        deliver_s    = 1'b0;
        ready_o      = '0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s && !jump_flag_i) begin
                    grant_fire_s = 1'b1;
                    ready_o      = pick_grant_s;
                    state_nxt_s  = REQ;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            REQ: begin
                if (bus_ack_i) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (bus_rvalid_i) begin
                    done_s      = 1'b1;
                    deliver_s   = !kill_r && !jump_flag_i;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch the granted address and owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= '0;
            owner_r <= 2'd0;
        end else if (grant_fire_s) begin
            addr_r  <= sel_addr_s;
            owner_r <= pick_idx_s;
        end
    end

    // Round-robin pointer and kill flag; a jump while busy only suppresses delivery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= 2'd0;
            kill_r   <= 1'b0;
        end else if (done_s) begin
            rr_ptr_r <= next_way(owner_r, NumWays);
            kill_r   <= 1'b0;
        end else if ((state_r != IDLE) && jump_flag_i) begin
            kill_r   <= 1'b1;
        end
    end

    // Data-phase timeout counter with sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= '0;
            err_o     <= 1'b0;
        end else if ((state_r == REQ) && bus_ack_i) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == WAIT) && !bus_rvalid_i && (tmo_cnt_r != TmoMax)) begin
            tmo_cnt_r <= tmo_cnt_r + CntW'(1);
            if (tmo_cnt_r == (TmoMax - CntW'(1))) begin
                err_o <= 1'b1;
            end
        end
    end

    // Registered delivery of the fetch packet to its owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_o   <= '0;
            data_ok_o <= '0;
        end else if (deliver_s) begin
            rdata_o   <= bus_rdata_i;
            data_ok_o <= owner_oh_s;
        end else begin
            data_ok_o <= '0;
        end
    end

    assign busy_o     = (state_r != IDLE);
    assign bus_req_o  = (state_r == REQ);
    assign bus_addr_o = bus_req_o ? addr_r : '0;

endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// Directed self-checking bench for fetch_bus_arbiter (two ways, timeout of 8).
module tb_fetch_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] addr0, addr1;
    logic        jump;
    logic [1:0]  ready, data_ok;
    logic [63:0] rdata;
    logic        busy, err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack, bus_rvalid;
    logic [63:0] bus_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_bus_arbiter #(
        .NumWays(2), .AddrWidth(32), .DataWidth(64), .TimeoutCycles(8)
    ) dut (
        .clk(clk), .reset(reset), .req_i(req), .addr_i({addr1, addr0}),
        .jump_flag_i(jump), .ready_o(ready), .data_ok_o(data_ok),
        .rdata_o(rdata), .busy_o(busy), .err_o(err), .bus_req_o(bus_req),
        .bus_addr_o(bus_addr), .bus_ack_i(bus_ack), .bus_rvalid_i(bus_rvalid),
        .bus_rdata_i(bus_rdata)
    );

    fetch_bus_arbiter_chk #(.NumWays(2)) u_chk (
        .clk(clk), .reset(reset), .ready(ready), .data_ok(data_ok)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; addr0 = 32'h0; addr1 = 32'h0; jump = 1'b0;
        bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = 64'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_data_ok", 64'(data_ok), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single fetch from way0
        req = 2'b01; addr0 = 32'h0000_1000; #1;
        chk("s1_ready", 64'(ready), 64'd1);
        @(negedge clk);
        req = 2'b00;
        chk("s1_bus_req", 64'(bus_req), 64'd1);
        chk("s1_bus_addr", 64'(bus_addr), 64'h1000);
        chk("s1_busy", 64'(busy), 64'd1);
        chk("s1_ready_req", 64'(ready), 64'd0);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("s1_bus_req_wait", 64'(bus_req), 64'd0);
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 64'hDEAD_BEEF_0000_0013;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("s1_data_ok", 64'(data_ok), 64'd1);
        chk("s1_rdata", rdata, 64'hDEAD_BEEF_0000_0013);
        chk("s1_busy_idle", 64'(busy), 64'd0);
        @(negedge clk);
        chk("s1_data_ok_pulse", 64'(data_ok), 64'd0);
        chk("s1_rdata_hold", rdata, 64'hDEAD_BEEF_0000_0013);

        // Reset between scenarios clears rdata and the round-robin pointer
        reset = 1'b1; #1;
        chk("r1_rdata", rdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Round-robin with both ways requesting continuously
        req = 2'b11; addr0 = 32'h100; addr1 = 32'h108; #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                chk("rr_data_ok", 64'(data_ok), (i % 2 == 1) ? 64'd1 : 64'd2);
                chk("rr_rdata", rdata, 64'hA0 + 64'(i - 1));
            end
            chk("rr_ready", 64'(ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            @(negedge clk);
            chk("rr_bus_req", 64'(bus_req), 64'd1);
            chk("rr_bus_addr", 64'(bus_addr), (i % 2 == 0) ? 64'h100 : 64'h108);
            bus_ack = 1'b1;
            @(negedge clk);
            bus_ack = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'hA0 + 64'(i);
            @(negedge clk);
            bus_rvalid = 1'b0;
        end
        req = 2'b00;
        chk("rr_data_ok_last", 64'(data_ok), 64'd2);
        chk("rr_rdata_last", rdata, 64'hA3);
        @(negedge clk);

        // Jump during WAIT suppresses delivery
        req = 2'b10; addr1 = 32'h2000; #1;
        chk("j_ready", 64'(ready), 64'd2);
        @(negedge clk);
        req = 2'b00; bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0; jump = 1'b1;
        @(negedge clk);
        jump = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h5555;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("j_data_ok", 64'(data_ok), 64'd0);
        chk("j_rdata", rdata, 64'hA3);
        chk("j_busy", 64'(busy), 64'd0);
        req = 2'b11; #1;
        chk("j_next_ready", 64'(ready), 64'd1);
        @(negedge clk);
        req = 2'b00;
        chk("j_next_addr", 64'(bus_addr), 64'h100);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h77;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("j_next_data_ok", 64'(data_ok), 64'd1);
        chk("j_next_rdata", rdata, 64'h77);

        // Ack stall with a jump in the middle; rr_ptr is 1, lone way0 wins
        req = 2'b01; addr0 = 32'h3000; #1;
        chk("st_ready", 64'(ready), 64'd1);
        @(negedge clk);
        req = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("st_bus_req", 64'(bus_req), 64'd1);
            chk("st_bus_addr", 64'(bus_addr), 64'h3000);
            chk("st_ready", 64'(ready), 64'd0);
            jump = (k == 2);
            @(negedge clk);
        end
        jump = 1'b0; bus_ack = 1'b1; req = 2'b00;
        @(negedge clk);
        bus_ack = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h99;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("st_data_ok", 64'(data_ok), 64'd0);
        chk("st_rdata", rdata, 64'h77);

        // Jump in IDLE blocks the grant
        req = 2'b10; addr1 = 32'h4000; jump = 1'b1; #1;
        chk("ij_ready", 64'(ready), 64'd0);
        @(negedge clk);
        chk("ij_busy", 64'(busy), 64'd0);
        jump = 1'b0; #1;
        chk("ij_ready_after", 64'(ready), 64'd2);

        // Timeout: no rvalid for 8 WAIT cycles
        @(negedge clk);
        req = 2'b00; bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        repeat (7) @(negedge clk);
        chk("to_err_early", 64'(err), 64'd0);
        @(negedge clk);
        chk("to_err_set", 64'(err), 64'd1);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", 64'(err), 64'd1);
        chk("to_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1; #1;
        chk("to_rst_busy", 64'(busy), 64'd0);
        chk("to_rst_err", 64'(err), 64'd0);
        chk("to_rst_bus_req", 64'(bus_req), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        req = 2'b11; #1;
        chk("to_rst_rr_ptr", 64'(ready), 64'd1);
        @(negedge clk);
        req = 2'b00;
        chk("rq_bus_req", 64'(bus_req), 64'd1);
        #2 reset = 1'b1; #1;
        chk("rq_rst_bus_req", 64'(bus_req), 64'd0);
        chk("rq_rst_bus_addr", 64'(bus_addr), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
